hazard_fwd_ctrl: RTL and testbench
==================================

# hazard_fwd_ctrl

Hazard and forwarding controller for the 5-stage pipeline. Tracks destination and source registers of the instructions in EX, MEM and WB with an internal shadow of the pipeline. From that shadow it drives the 2-bit EX-stage operand forward selects, the load-use stall and bubble, branch flush and memory-wait freeze. It sits beside the ID/EX, EX/MEM and MEM/WB registers; its outputs drive their enables and clears and the operand muxes.

## Interface
- `REG_W`, 5: register-number width.
- `CNT_W`, 16: width of the stall performance counter.

- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in REG_W: ID source registers.
- `id_use_rs`, `id_use_rt` in 1: ID instruction actually reads rs / rt.
- `id_rd` in REG_W: ID destination register, already muxed rt/rd/31.
- `id_regwrite`, `id_memread` in 1: ID instruction writes the register file / is a load.
- `ex_branch_taken` in 1: EX resolved a taken branch or jump.
- `mem_wait` in 1: data memory not ready; the pipeline freezes.
- `fwd_a`, `fwd_b` out 2: EX operand select. 00 = ID/EX register value, 01 = EX/MEM ALU result, 10 = MEM/WB writeback value; 11 is never driven.
- `pc_hold` out 1: hold PC.
- `ifid_hold` out 1: hold IF/ID.
- `ifid_flush` out 1: clear IF/ID.
- `idex_bubble` out 1: load a NOP into ID/EX.
- `freeze` out 1: hold all pipeline registers.
- `stall_cnt` out CNT_W: saturating count of stall and freeze cycles.

## Operation
- **Shadow pipeline.** Three stage records: ex, mem and wb.
  - The ex record holds {valid, rs, rt, use_rs, use_rt, rd, regwrite, memread}.
  - The mem and wb records hold {valid, rd, regwrite}.
- **Record advance.** On each non-freeze edge, ex→mem→wb shifts.
  - The ex record loads the ID inputs.
  - If `idex_bubble` is set, the ex record loads valid=0 instead.
- **Forward selects.** Computed from the ex record against mem/wb:
  - `fwd_a` = 01 if mem.valid & mem.regwrite & mem.rd≠0 & mem.rd==ex.rs & ex.use_rs.
  - Otherwise `fwd_a` = 10 under the same test against wb.
  - Otherwise `fwd_a` = 00.
  - MEM has priority over WB. `fwd_b` is identical using rt / use_rt.
  - `fwd_a` = `fwd_b` = 00 whenever ex.valid=0.
- **Load-use hazard.** `lu` = id_valid & ex.valid & ex.memread & ex.rd≠0 & ((id_use_rs & id_rs==ex.rd) | (id_use_rt & id_rt==ex.rd)).
- **FSM.** States RUN, LU_STALL and FROZEN.
  - RUN → FROZEN when `mem_wait`.
  - RUN → LU_STALL when `lu` & !`ex_branch_taken` & !`mem_wait`.
  - LU_STALL always lasts one cycle. It exits to FROZEN if `mem_wait`, otherwise to RUN.
  - FROZEN stays while `mem_wait`, then returns to RUN. It never skips the pending load-use, because `lu` is re-evaluated from held state.
- **Outputs by condition, in priority order:**
  - `mem_wait`: `freeze`=1, `pc_hold`=1, `ifid_hold`=1. Flush and bubble are 0. Records hold.
  - `ex_branch_taken`: `ifid_flush`=1 and `idex_bubble`=1. `lu` is ignored and there is no hold.
  - `lu` (RUN): `pc_hold`=1, `ifid_hold`=1, `idex_bubble`=1.
  - Otherwise all control outputs are 0.
- **Stall counter.** `stall_cnt` increments on each cycle with `pc_hold`=1, and saturates at all-ones.

## Timing
- **Reset.** Applied at the `rst` edge:
  - All record valid bits are 0, the FSM is in RUN and `stall_cnt`=0.
  - Consequently `fwd_a`=`fwd_b`=00 and all control outputs are 0 from the first cycle after reset.
- **`rst` precedence.** `rst` overrides `mem_wait`. Reset mid-stall or mid-freeze returns the FSM to RUN with empty records.
- **Latency.**
  - Forward selects are combinational from registers, so they are valid at the start of the cycle the consumer is in EX. There is zero input-to-output latency on the id_* ports.
  - Hazard and control outputs are combinational from the id_* ports and the records, valid in the same cycle.
- **Load-use cost.** Exactly one bubble. On the next cycle the load is in mem, so the dependent instruction gets `fwd`=01? No: loads forward through WB, so after one bubble the dependent sees the load in wb and `fwd`=10.
- **Dependence on r0.** Never stalls and never forwards.
- **Back-to-back writers to the same rd.** The youngest (mem) wins.

## Test plan
- **Reset.** `rst`=1 for 2 cycles with random inputs → all outputs 0, `stall_cnt`=0.
- **ALU chain.** `add r3` then `sub r4,r3,r5` → second instruction in EX sees `fwd_a`=01. A third instruction using r3 sees `fwd_a`=10.
- **Load-use.** `lw r2` then `add r6,r2,r7` → one cycle with `pc_hold`=`ifid_hold`=`idex_bubble`=1. The add then sees `fwd_a`=10. `stall_cnt`=1.
- **Flush versus load-use.** Load-use coincides with `ex_branch_taken`=1 → `ifid_flush`=`idex_bubble`=1 and `pc_hold`=0. No stall occurs and `stall_cnt` is unchanged.
- **Freeze during load-use.** `mem_wait` asserted 3 cycles during LU_STALL → `freeze`=1 for 3 cycles with the records unchanged. Then exactly one more bubble-free resume with correct `fwd`. `stall_cnt` increases by 4.
- **r0 and saturation.** Writes to r0 followed by a reader of r0 → `fwd`=00 and no stall. Forcing `stall_cnt` to all-ones then stalling → the counter stays at all-ones.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - hazard detection and operand forwarding control for a 5-stage pipeline
module hazard_fwd_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_wait,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FROZEN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Shadow of the EX stage: everything needed for forwarding and load-use checks
    logic             ex_valid_q, ex_use_rs_q, ex_use_rt_q, ex_regwrite_q, ex_memread_q;
    logic [REG_W-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
    // Shadows of MEM and WB: only the write-back identity matters there
    logic             mem_valid_q, mem_regwrite_q;
    logic [REG_W-1:0] mem_rd_q;
    logic             wb_valid_q, wb_regwrite_q;
    logic [REG_W-1:0] wb_rd_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic lu;
    logic lu_stall;
    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

    // A load in EX whose (non-r0) destination feeds the instruction in ID
    always_comb begin
        lu = id_valid && ex_valid_q && ex_memread_q && (ex_rd_q != '0) &&
             ((id_use_rs && (id_rs == ex_rd_q)) || (id_use_rt && (id_rt == ex_rd_q)));
        // LU_STALL always holds a bubble in EX, so lu cannot re-fire there
        lu_stall = lu && (state_q != LU_STALL);
    end

    // Forward selects: youngest producer (MEM) beats WB; r0 never forwards
    always_comb begin
        mem_hit_a = mem_valid_q && mem_regwrite_q && (mem_rd_q != '0) &&
                    (mem_rd_q == ex_rs_q) && ex_use_rs_q;
        mem_hit_b = mem_valid_q && mem_regwrite_q && (mem_rd_q != '0) &&
                    (mem_rd_q == ex_rt_q) && ex_use_rt_q;
        wb_hit_a  = wb_valid_q && wb_regwrite_q && (wb_rd_q != '0) &&
                    (wb_rd_q == ex_rs_q) && ex_use_rs_q;
        wb_hit_b  = wb_valid_q && wb_regwrite_q && (wb_rd_q != '0) &&
                    (wb_rd_q == ex_rt_q) && ex_use_rt_q;
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_valid_q) begin
            if (mem_hit_a)     fwd_a = 2'b01;
            else if (wb_hit_a) fwd_a = 2'b10;
            if (mem_hit_b)     fwd_b = 2'b01;
            else if (wb_hit_b) fwd_b = 2'b10;
        end
    end

    // Pipeline control outputs in priority order: freeze, flush, load-use stall
    always_comb begin
        freeze      = 1'b0;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (mem_wait) begin
            freeze    = 1'b1;
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu_stall) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    // FSM next state: a memory wait dominates, a taken branch cancels the stall
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (mem_wait)                      state_d = FROZEN;
                else if (lu && !ex_branch_taken)   state_d = LU_STALL;
            end
            LU_STALL: state_d = mem_wait ? FROZEN : RUN;
            FROZEN:   state_d = mem_wait ? FROZEN : RUN;
            default:  state_d = RUN;
        endcase
    end

    // Stall counter counts every PC-hold cycle and sticks at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (pc_hold && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    // State, counter and shadow records; records hold while frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            ex_valid_q     <= 1'b0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_use_rs_q    <= 1'b0;
            ex_use_rt_q    <= 1'b0;
            ex_rd_q        <= '0;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= '0;
            mem_regwrite_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_regwrite_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!freeze) begin
                wb_valid_q     <= mem_valid_q;
                wb_rd_q        <= mem_rd_q;
                wb_regwrite_q  <= mem_regwrite_q;
                mem_valid_q    <= ex_valid_q;
                mem_rd_q       <= ex_rd_q;
                mem_regwrite_q <= ex_regwrite_q;
                ex_valid_q     <= id_valid && !idex_bubble;
                ex_rs_q        <= id_rs;
                ex_rt_q        <= id_rt;
                ex_use_rs_q    <= id_use_rs;
                ex_use_rt_q    <= id_use_rt;
                ex_rd_q        <= id_rd;
                ex_regwrite_q  <= id_regwrite;
                ex_memread_q   <= id_memread;
            end
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - directed self-checking bench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_use_rs, id_use_rt, id_regwrite, id_memread;
    logic        ex_branch_taken, mem_wait;
    logic [1:0]  fwd_a, fwd_b;
    logic        pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze;
    logic [15:0] stall_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    hazard_fwd_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .freeze(freeze), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic [4:0] rd,
                            input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_rd = rd; id_regwrite = rw; id_memread = mr;
        #1;
    endtask

    task automatic idle_id();
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        mem_wait = 1'b0;
        ex_branch_taken = 1'b0;
        idle_id();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                     5'($urandom), 1'($urandom), 1'($urandom));
            ex_branch_taken = 1'($urandom);
            mem_wait = 1'($urandom);
            tick();
        end
        rst = 1'b0;
        ex_branch_taken = 1'b0;
        mem_wait = 1'b0;
        idle_id();
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd_b: got %b want 00", fwd_b); end
        checks++; if ({pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze}); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_alu_chain();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add r3,r1,r2
        tick();
        drive_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // sub r4,r3,r5
        checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL alu_no_stall: got %b want 0", pc_hold); end
        tick();
        drive_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);   // or r8,r3,r4
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL alu_fwd_a_mem: got %b want 01", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL alu_fwd_b_none: got %b want 00", fwd_b); end
        tick();
        idle_id();
        checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL alu_fwd_a_wb: got %b want 10", fwd_a); end
        checks++; if (fwd_b !== 2'b01) begin errors++; $display("FAIL alu_fwd_b_mem: got %b want 01", fwd_b); end
        tick();
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL alu_fwd_a_empty: got %b want 00", fwd_a); end
        drain();
    endtask

    task automatic test_back_to_back();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);   // add r7
        tick();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);   // add r7 again
        tick();
        drive_id(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // reader of r7
        tick();
        idle_id();
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL b2b_fwd_a: got %b want 01", fwd_a); end
        checks++; if (fwd_b !== 2'b01) begin errors++; $display("FAIL b2b_fwd_b: got %b want 01", fwd_b); end
        drain();
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);   // lw r2
        tick();
        drive_id(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // add r6,r2,r7
        checks++; if ({pc_hold, ifid_hold, idex_bubble, ifid_flush, freeze} !== 5'b11100) begin
            errors++; $display("FAIL lu_stall: got %b want 11100", {pc_hold, ifid_hold, idex_bubble, ifid_flush, freeze}); end
        exp_cnt = exp_cnt + 16'd1;
        tick();
        checks++; if ({pc_hold, ifid_hold, idex_bubble} !== 3'b000) begin
            errors++; $display("FAIL lu_one_bubble: got %b want 000", {pc_hold, ifid_hold, idex_bubble}); end
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL lu_bubble_fwd: got %b want 00", fwd_a); end
        tick();
        idle_id();
        checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL lu_fwd_a: got %b want 10", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL lu_fwd_b: got %b want 00", fwd_b); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_flush_vs_lu();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);   // lw r2
        tick();
        drive_id(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        checks++; if ({ifid_flush, idex_bubble, pc_hold, ifid_hold, freeze} !== 5'b11000) begin
            errors++; $display("FAIL flush_ctrl: got %b want 11000", {ifid_flush, idex_bubble, pc_hold, ifid_hold, freeze}); end
        tick();
        ex_branch_taken = 1'b0;
        idle_id();
        checks++; if ({pc_hold, idex_bubble} !== 2'b00) begin errors++; $display("FAIL flush_no_stall: got %b want 00", {pc_hold, idex_bubble}); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_freeze_lu();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);   // lw r2
        tick();
        drive_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // add r6,r7,r2
        checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL frz_lu_bubble: got %b want 1", idex_bubble); end
        exp_cnt = exp_cnt + 16'd1;
        tick();
        mem_wait = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({freeze, pc_hold, ifid_hold, idex_bubble, ifid_flush} !== 5'b11100) begin
                errors++; $display("FAIL frz_ctrl[%0d]: got %b want 11100", i, {freeze, pc_hold, ifid_hold, idex_bubble, ifid_flush}); end
            checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL frz_fwd[%0d]: got %b want 00", i, fwd_b); end
            exp_cnt = exp_cnt + 16'd1;
            tick();
        end
        mem_wait = 1'b0;
        #1;
        checks++; if ({freeze, pc_hold, idex_bubble} !== 3'b000) begin
            errors++; $display("FAIL frz_resume: got %b want 000", {freeze, pc_hold, idex_bubble}); end
        tick();
        idle_id();
        checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL frz_fwd_b: got %b want 10", fwd_b); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL frz_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_freeze_holds_fwd();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add r3
        tick();
        drive_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // sub r4,r3,r5
        tick();
        idle_id();
        mem_wait = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL hold_fwd[%0d]: got %b want 01", i, fwd_a); end
            exp_cnt = exp_cnt + 16'd1;
            tick();
        end
        mem_wait = 1'b0;
        #1;
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL hold_fwd_release: got %b want 01", fwd_a); end
        drain();
    endtask

    task automatic test_r0();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);   // add r0
        tick();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);   // lw r0
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // reader of r0
        checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL r0_no_stall: got %b want 0", pc_hold); end
        tick();
        idle_id();
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL r0_fwd: got %b want 0000", {fwd_a, fwd_b}); end
        drain();
    endtask

    task automatic test_saturation();
        mem_wait = 1'b1;
        repeat (65535) tick();
        exp_cnt = 16'hFFFF;
        mem_wait = 1'b0;
        #1;
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL sat_reach: got %0h want %0h", stall_cnt, exp_cnt); end
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);   // lw r2
        tick();
        drive_id(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b want 1", pc_hold); end
        tick();
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL sat_hold: got %0h want %0h", stall_cnt, exp_cnt); end
        drain();
    endtask

    task automatic test_reset_precedence();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        mem_wait = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_wait = 1'b0;
        idle_id();
        exp_cnt = 16'd0;
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL rstp_fwd: got %b want 00", fwd_a); end
        checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL rstp_cnt: got %0d want 0", stall_cnt); end
        checks++; if ({pc_hold, freeze} !== 2'b00) begin errors++; $display("FAIL rstp_ctrl: got %b want 00", {pc_hold, freeze}); end
    endtask

    initial begin
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        mem_wait = 1'b0;
        idle_id();
        test_reset();
        test_alu_chain();
        test_back_to_back();
        test_load_use();
        test_flush_vs_lu();
        test_freeze_lu();
        test_freeze_holds_fwd();
        test_r0();
        test_saturation();
        test_reset_precedence();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
